// File: rtl/rst_defs.sv
// Shared reset-infrastructure definitions: sequencer state encoding, counter
// sizing helpers and parameter legality checks for clock/reset blocks.
package rst_defs;

    typedef enum logic [2:0] {
        RST_ASSERT   = 3'd0,
        RST_DEBOUNCE = 3'd1,
        RST_RELEASE  = 3'd2,
        RST_RUN      = 3'd3,
        RST_HOLD     = 3'd4
    } rstState_t;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width needed to hold 0..maxCount, never narrower than one bit.
    function automatic int cntWidth(input int maxCount);
        return (maxCount < 1) ? 1 : $clog2(maxCount + 1);
    endfunction

    function automatic bit syncStagesLegal(input int syncStages);
        return syncStages >= 2;
    endfunction

    function automatic bit seqParamsLegal(input int syncStages,
                                          input int debounceCycles,
                                          input int numDomains,
                                          input int releaseGap,
                                          input int softHoldCycles);
        return syncStagesLegal(syncStages) && (debounceCycles >= 1) &&
               (numDomains >= 1) && (numDomains <= 16) &&
               (releaseGap >= 1) && (softHoldCycles >= 1);
    endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Reset synchroniser: asynchronously cleared flop chain whose output rises a
// fixed number of clock edges after the asynchronous reset is released.
module rst_sync_chain
    import rst_defs::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_async_n,
    output logic o_syncOut
);

    if (!syncStagesLegal(SYNC_STAGES)) begin : g_badStages
        $error("rst_sync_chain: SYNC_STAGES must be 2 or more");
    end

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign o_syncOut = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: synchronised release, debounce, staggered per-domain
// deassertion and software-requested hold, all on a single clock.
module rst_sequencer
    import rst_defs::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter int DEBOUNCE_CYCLES  = 16,
    parameter int NUM_DOMAINS      = 3,
    parameter int RELEASE_GAP      = 4,
    parameter int SOFT_HOLD_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst_async_n,
    input  logic                   soft_rst_req,
    output logic [NUM_DOMAINS-1:0] rst_sync,
    output logic                   rst_done
);

    if (!seqParamsLegal(SYNC_STAGES, DEBOUNCE_CYCLES, NUM_DOMAINS,
                        RELEASE_GAP, SOFT_HOLD_CYCLES)) begin : g_badParams
        $error("rst_sequencer: illegal parameter value");
    end

    localparam int CW = cntWidth(maxInt(DEBOUNCE_CYCLES, SOFT_HOLD_CYCLES) - 1);
    localparam int GW = cntWidth(RELEASE_GAP - 1);
    localparam int RW = cntWidth(NUM_DOMAINS);

    localparam logic [CW-1:0] DEB_END  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_END = CW'(SOFT_HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_END  = GW'(RELEASE_GAP - 1);
    localparam logic [RW-1:0] ALL_REL  = RW'(NUM_DOMAINS);

    logic                   w_syncOut;
    rstState_t              r_state, w_stateNext;
    logic [CW-1:0]          r_cnt, w_cntNext;
    logic [GW-1:0]          r_gap, w_gapNext;
    logic [RW-1:0]          r_relCnt, w_relCntNext;
    logic [NUM_DOMAINS-1:0] r_rstSync, w_rstSyncNext;
    logic                   r_done, w_doneNext;

    rst_sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_syncChain (
        .clk         (clk),
        .rst_async_n (rst_async_n),
        .o_syncOut   (w_syncOut)
    );

    // r_relCnt is the number of domains already released; domains below it are out of reset.
    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = r_cnt;
        w_gapNext    = r_gap;
        w_relCntNext = r_relCnt;
        w_doneNext   = r_done;

        case (r_state)
            RST_ASSERT: begin
                if (w_syncOut) begin
                    w_stateNext = RST_DEBOUNCE;
                    w_cntNext   = '0;
                end
            end
            RST_DEBOUNCE: begin
                if (r_cnt >= DEB_END) begin
                    w_stateNext  = RST_RELEASE;
                    w_gapNext    = '0;
                    w_relCntNext = RW'(1);
                end else begin
                    w_cntNext = r_cnt + CW'(1);
                end
            end
            RST_RELEASE: begin
                if (soft_rst_req) begin
                    w_stateNext  = RST_HOLD;
                    w_cntNext    = '0;
                    w_relCntNext = '0;
                    w_doneNext   = 1'b0;
                end else if (r_relCnt == ALL_REL) begin
                    w_stateNext = RST_RUN;
                    w_doneNext  = 1'b1;
                end else if (r_gap >= GAP_END) begin
                    w_relCntNext = r_relCnt + RW'(1);
                    w_gapNext    = '0;
                end else begin
                    w_gapNext = r_gap + GW'(1);
                end
            end
            RST_RUN: begin
                if (soft_rst_req) begin
                    w_stateNext  = RST_HOLD;
                    w_cntNext    = '0;
                    w_relCntNext = '0;
                    w_doneNext   = 1'b0;
                end
            end
            RST_HOLD: begin
                if (soft_rst_req) begin
                    w_cntNext = '0;
                end else if (r_cnt >= HOLD_END) begin
                    w_stateNext  = RST_RELEASE;
                    w_gapNext    = '0;
                    w_relCntNext = RW'(1);
                end else begin
                    w_cntNext = r_cnt + CW'(1);
                end
            end
            default: begin
                w_stateNext  = RST_ASSERT;
                w_cntNext    = '0;
                w_gapNext    = '0;
                w_relCntNext = '0;
                w_doneNext   = 1'b0;
            end
        endcase

        for (int i = 0; i < NUM_DOMAINS; i++) begin
            w_rstSyncNext[i] = (RW'(i) >= w_relCntNext);
        end
    end

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            r_state   <= RST_ASSERT;
            r_cnt     <= '0;
            r_gap     <= '0;
            r_relCnt  <= '0;
            r_rstSync <= '1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_gap     <= w_gapNext;
            r_relCnt  <= w_relCntNext;
            r_rstSync <= w_rstSyncNext;
            r_done    <= w_doneNext;
        end
    end

    assign rst_sync = r_rstSync;
    assign rst_done = r_done;

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 The parameter list SHALL be:
- SYNC_STAGES, 2, synchroniser depth, legal range 2 or more.
- DEBOUNCE_CYCLES, 16, consecutive stable-high cycles required before release, 1 or more.
- NUM_DOMAINS, 3, number of reset domains, 1 to 16.
- RELEASE_GAP, 4, cycles between consecutive domain releases, 1 or more.
- SOFT_HOLD_CYCLES, 8, assertion length for a software reset, 1 or more.

REQ-002 The ports SHALL be, clock and reset first:
- clk, input, 1 bit: the single clock.
- rst_async_n, input, 1 bit: asynchronous, active-low system reset (board pin or POR).
- soft_rst_req, input, 1 bit: synchronous software/watchdog reset request, level-sampled.
- rst_sync, output, NUM_DOMAINS bits: active-high per-domain resets; asserted asynchronously, deasserted synchronously.
- rst_done, output, 1 bit: high when all domains are released.

REQ-003 The block SHALL use one clock (clk) and one asynchronous active-low reset (rst_async_n); there is no other reset input.

Function
REQ-004 rst_async_n low SHALL force rst_sync to all-ones and rst_done to 0 immediately, without waiting for a clock edge.

REQ-005 rst_async_n SHALL pass through a SYNC_STAGES-deep flop chain that is asynchronously cleared to 0; only the chain output feeds the FSM.

REQ-006 The FSM SHALL have four states: ASSERT, DEBOUNCE, RELEASE, RUN, plus HOLD for software reset. The reset state is ASSERT.

REQ-007 ASSERT->DEBOUNCE SHALL occur on the first edge at which the synchroniser output is 1.

REQ-008 In DEBOUNCE, a counter SHALL increment each cycle. On reaching DEBOUNCE_CYCLES-1 the FSM SHALL move to RELEASE and clear the gap counter.

REQ-009 Let E0 be the first edge sampling rst_async_n high. rst_sync[i] SHALL deassert at edge E0+SYNC_STAGES+DEBOUNCE_CYCLES+i*RELEASE_GAP. Lower index releases first.

REQ-010 Once released, a domain SHALL stay released until rst_async_n falls or a software reset occurs; release is monotonic within a sequence.

REQ-011 After rst_sync[NUM_DOMAINS-1] deasserts, the FSM SHALL enter RUN and rst_done SHALL rise one edge later.

REQ-012 soft_rst_req sampled high in RELEASE or RUN SHALL:
- assert all rst_sync bits and clear rst_done at the next edge;
- load the hold counter and enter HOLD.

REQ-013 HOLD SHALL last SOFT_HOLD_CYCLES cycles, then go to RELEASE, skipping DEBOUNCE. Release timing then follows REQ-009 with the debounce term replaced by the hold end.

REQ-014 soft_rst_req high during HOLD SHALL reload the hold counter, extending HOLD. soft_rst_req SHALL be ignored in ASSERT and DEBOUNCE.

REQ-015 soft_rst_req held continuously high SHALL keep the block in HOLD indefinitely.

REQ-016 When NUM_DOMAINS=1, RELEASE SHALL last one cycle and RELEASE_GAP SHALL have no effect.

REQ-017 Counter widths SHALL be $clog2 of the maximum count plus 1. Counters SHALL saturate and never wrap.

Reset
REQ-018 rst_async_n low SHALL return the block to its reset state from any state, mid-sequence included:
- synchroniser all 0, FSM ASSERT, all counters 0, rst_sync all 1, rst_done 0.

REQ-019 A rst_async_n glitch of any width SHALL restart the full sequence from REQ-007. The FSM SHALL never exit with a partial release.

Structure
REQ-020 FSM state encodings and the parameter legality checks SHALL live in the shared reset package/include (rst_defs). That file SHALL be reused by future clock/reset blocks.

REQ-021 The synchroniser SHALL be a separate sub-module, rst_sync_chain, parametrised by SYNC_STAGES. It SHALL be asynchronously cleared and is the only flop chain touching rst_async_n.

REQ-022 Illegal parameter values SHALL produce an elaboration-time error.

Verification
REQ-023 Power-on with defaults: release rst_async_n before edge E0. Required: rst_sync[0] falls at E0+18, [1] at E0+22, [2] at E0+26; rst_done rises at E0+27.

REQ-024 Mid-sequence reset: pull rst_async_n low for 1 ns at E0+20. Required: rst_sync returns to 3'b111 immediately, then the full REQ-023 timing repeats from the next E0.

REQ-025 Software reset in RUN: pulse soft_rst_req for one cycle at edge T. Required: rst_sync=3'b111 and rst_done=0 at T+1; domain 0 releases at T+1+8, then domains 1 and 2 at 4-cycle gaps.

REQ-026 Hold extension: pulse soft_rst_req again 5 cycles into HOLD. Required: release is delayed by 5 cycles relative to REQ-025.

REQ-027 Parameter sweep: SYNC_STAGES=3, DEBOUNCE_CYCLES=1, NUM_DOMAINS=1. Required: rst_sync[0] falls at E0+4; rst_done at E0+5.

REQ-028 Ignored request: hold soft_rst_req high throughout DEBOUNCE. Required: REQ-023 timing is unchanged up to RELEASE, then HOLD is entered on the first RELEASE cycle.
